// File: rtl/comp_len_fixup.sv
// Store-and-forward packet buffer that rewrites the IPv4 Total Length field of
// compressed packets before replaying them downstream; oversize packets are dropped whole.
module comp_len_fixup #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [255:0] s_tdata,
  input  logic [31:0]  s_tkeep,
  input  logic         s_tvalid,
  input  logic         s_tlast,
  output logic         s_tready,
  input  logic         s_comp,
  output logic [255:0] m_tdata,
  output logic [31:0]  m_tkeep,
  output logic         m_tvalid,
  output logic         m_tlast,
  input  logic         m_tready,
  output logic [31:0]  pkt_cnt,
  output logic [15:0]  drop_cnt
);

  typedef enum logic [1:0] {FILL, DROP, FIXUP, DRAIN} state_t;

  state_t            state;
  logic [287:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   nbeats;
  logic [15:0]       byte_cnt;
  logic [255:0]      hdr_reg;
  logic              comp_reg;

  logic              accept;
  logic              load;
  logic              last_hs;
  logic [287:0]      rd_word;

  function automatic logic [5:0] popcount(input logic [31:0] keep);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'd0, keep[i]};
    return n;
  endfunction

  // Total Length = frame bytes minus the 14-byte Ethernet header, big-endian at bytes 16/17.
  function automatic logic [255:0] patch_len(input logic [255:0] hdr, input logic [15:0] bytes);
    logic [15:0]  len;
    logic [255:0] h;
    len = bytes - 16'd14;
    h = hdr;
    h[135:128] = len[15:8];
    h[143:136] = len[7:0];
    return h;
  endfunction

  assign s_tready = aresetn && (state == FILL || state == DROP);
  assign accept   = s_tvalid && s_tready;
  assign load     = (state == DRAIN) && (rd_ptr != nbeats) && (!m_tvalid || m_tready);
  assign last_hs  = m_tvalid && m_tready && m_tlast;
  assign rd_word  = mem[rd_ptr[ADDR_W-1:0]];

  // Packet buffer and header copy
  always_ff @(posedge aclk) begin
    if (state == FILL && accept) begin
      mem[wr_ptr] <= {s_tkeep, s_tdata};
      if (wr_ptr == '0) hdr_reg <= s_tdata;
    end else if (state == FIXUP && comp_reg && byte_cnt >= 16'd34) begin
      hdr_reg <= patch_len(hdr_reg, byte_cnt);
    end
  end

  // Control FSM and registered output stage
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= FILL;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      nbeats   <= '0;
      byte_cnt <= '0;
      comp_reg <= 1'b0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            wr_ptr   <= wr_ptr + 1'b1;
            byte_cnt <= byte_cnt + {10'd0, popcount(s_tkeep)};
            if (wr_ptr == '0) comp_reg <= s_comp;
            if (s_tlast) begin
              nbeats <= {1'b0, wr_ptr} + 1'b1;
              state  <= FIXUP;
            end else if (wr_ptr == ADDR_W'(DEPTH - 1)) begin
              state <= DROP;
            end
          end
        end
        DROP: begin
          if (accept && s_tlast) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            wr_ptr   <= '0;
            byte_cnt <= '0;
            state    <= FILL;
          end
        end
        FIXUP: begin
          rd_ptr <= '0;
          state  <= DRAIN;
        end
        DRAIN: begin
          if (load) begin
            m_tvalid <= 1'b1;
            m_tdata  <= (rd_ptr == '0) ? hdr_reg : rd_word[255:0];
            m_tkeep  <= rd_word[287:256];
            m_tlast  <= (rd_ptr == nbeats - 1'b1);
            rd_ptr   <= rd_ptr + 1'b1;
          end else if (last_hs) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            pkt_cnt  <= pkt_cnt + 32'd1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            byte_cnt <= '0;
            state    <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_len_fixup.sv
// Directed bench for comp_len_fixup: table of packets with hand-computed length patches,
// plus overflow-drop and reset-during-drain sequences.
module tb_comp_len_fixup;

  typedef struct {
    int          nb;
    logic [31:0] lastk;
    logic        comp;
    logic        patch;
    logic [7:0]  b16;
    logic [7:0]  b17;
    logic        rnd;
  } vec_t;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [255:0] s_tdata = '0;
  logic [31:0]  s_tkeep = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic         s_tready;
  logic         s_comp = 1'b0;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready = 1'b1;
  logic [31:0]  pkt_cnt;
  logic [15:0]  drop_cnt;

  int tests = 0;
  int fails = 0;
  int exp_pkt = 0;

  logic [255:0] in_d [128];
  logic [31:0]  in_k [128];
  logic [255:0] out_d [128];
  logic [31:0]  out_k [128];
  logic         out_l [128];
  int           out_n;

  comp_len_fixup #(.DEPTH(64), .ADDR_W(6)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .s_comp(s_comp),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_pkt(input int nb, input logic [31:0] lastk, input int seed);
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 32; k++) in_d[b][8*k +: 8] = 8'((seed + b * 5 + k * 3) & 255);
      in_k[b] = (b == nb - 1) ? lastk : 32'hFFFF_FFFF;
    end
  endtask

  task automatic send_pkt(input int nb, input logic comp, input logic gaps);
    int g;
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) @(negedge aclk);
      @(negedge aclk);
      s_tvalid = 1'b1;
      s_tdata  = in_d[b];
      s_tkeep  = in_k[b];
      s_tlast  = (b == nb - 1);
      s_comp   = (b == 0) ? comp : ~comp;
      g = 0;
      while (!s_tready && g < 200) begin
        @(negedge aclk);
        g++;
      end
      if (g >= 200) check("s_tready_timeout", 0, 1);
      @(posedge aclk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
    end
  endtask

  task automatic recv_pkt(input logic rnd, input int stop_after, output int first);
    int           cyc;
    logic         done;
    logic         pv, pr, pl;
    logic [255:0] pd;
    logic [31:0]  pk;
    cyc = 0; done = 1'b0; first = -1; out_n = 0;
    pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0; pk = '0;
    while (!done && cyc < 2000) begin
      @(negedge aclk);
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_tvalid && first < 0) first = cyc;
      if (pv && !pr) begin
        tests++;
        if (!m_tvalid || m_tdata !== pd || m_tkeep !== pk || m_tlast !== pl) begin
          fails++;
          $display("FAIL stall_stable: got v=%0b l=%0b k=%0h expected v=1 l=%0b k=%0h", m_tvalid, m_tlast, m_tkeep, pl, pk);
        end
      end
      if (m_tvalid) check("s_tready_in_drain", s_tready, 0);
      if (m_tvalid && m_tready && out_n < 128) begin
        out_d[out_n] = m_tdata;
        out_k[out_n] = m_tkeep;
        out_l[out_n] = m_tlast;
        out_n++;
        if (m_tlast || out_n == stop_after) done = 1'b1;
      end
      pv = m_tvalid; pr = m_tready; pd = m_tdata; pk = m_tkeep; pl = m_tlast;
      cyc++;
    end
    if (!done) check("recv_timeout", 0, 1);
  endtask

  task automatic verify(input vec_t v);
    logic [255:0] e;
    check("beat_count", out_n, v.nb);
    for (int i = 0; i < out_n && i < v.nb; i++) begin
      e = in_d[i];
      if (i == 0 && v.patch) begin
        e[135:128] = v.b16;
        e[143:136] = v.b17;
      end
      check($sformatf("tdata[%0d]", i), out_d[i], e);
      check($sformatf("tkeep[%0d]", i), out_k[i], in_k[i]);
      check($sformatf("tlast[%0d]", i), out_l[i], (i == v.nb - 1));
    end
  endtask

  task automatic run_vec(input vec_t v, input int seed);
    int first;
    build_pkt(v.nb, v.lastk, seed);
    send_pkt(v.nb, v.comp, v.rnd);
    recv_pkt(v.rnd, 0, first);
    check("first_valid_latency", first, 2);
    verify(v);
    exp_pkt++;
    @(negedge aclk);
    check("m_tvalid_after_pkt", m_tvalid, 0);
    check("s_tready_after_pkt", s_tready, 1);
    check("pkt_cnt", pkt_cnt, exp_pkt);
    m_tready = 1'b1;
  endtask

  initial begin
    vec_t tbl [9];
    vec_t fwd2;
    int   vcnt;
    int   first;
    tbl[0] = '{48, 32'h0000_03FF, 1'b1, 1'b1, 8'h05, 8'hDC, 1'b0};
    tbl[1] = '{20, 32'h0000_FFFF, 1'b1, 1'b1, 8'h02, 8'h62, 1'b0};
    tbl[2] = '{20, 32'h0000_FFFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[3] = '{1,  32'hFFFF_FFFF, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[4] = '{2,  32'h0000_0003, 1'b1, 1'b1, 8'h00, 8'h14, 1'b0};
    tbl[5] = '{2,  32'h0000_0001, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[6] = '{64, 32'hFFFF_FFFF, 1'b1, 1'b1, 8'h07, 8'hF2, 1'b0};
    tbl[7] = '{10, 32'h0000_00FF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[8] = '{10, 32'h0000_0FFF, 1'b1, 1'b1, 8'h01, 8'h1E, 1'b1};
    fwd2   = '{2,  32'hFFFF_FFFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};

    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset_s_tready", s_tready, 0);
    check("reset_m_tvalid", m_tvalid, 0);
    check("reset_m_tlast", m_tlast, 0);
    check("reset_m_tdata", m_tdata, 0);
    check("reset_m_tkeep", m_tkeep, 0);
    check("reset_pkt_cnt", pkt_cnt, 0);
    check("reset_drop_cnt", drop_cnt, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("s_tready_after_reset", s_tready, 1);

    // Oversize packet is dropped, the next one is forwarded intact.
    build_pkt(70, 32'hFFFF_FFFF, 3);
    send_pkt(70, 1'b1, 1'b0);
    vcnt = 0;
    repeat (10) begin
      @(negedge aclk);
      if (m_tvalid) vcnt++;
    end
    check("drop_no_output", vcnt, 0);
    check("drop_cnt", drop_cnt, 1);
    check("drop_s_tready", s_tready, 1);
    run_vec(fwd2, 11);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], 20 + i * 7);
    check("drop_cnt_final", drop_cnt, 1);

    // Reset in the middle of draining a 10-beat packet.
    build_pkt(10, 32'hFFFF_FFFF, 9);
    send_pkt(10, 1'b1, 1'b0);
    recv_pkt(1'b0, 5, first);
    check("pre_reset_beats", out_n, 5);
    aresetn = 1'b0;
    @(posedge aclk);
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    exp_pkt = 0;
    @(negedge aclk);
    check("mid_reset_m_tvalid", m_tvalid, 0);
    check("mid_reset_pkt_cnt", pkt_cnt, 0);
    check("mid_reset_drop_cnt", drop_cnt, 0);
    check("mid_reset_s_tready", s_tready, 1);
    run_vec(tbl[1], 77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
